imem_port_ctrl: RTL and testbench
=================================

# imem_port_ctrl

Single-port access controller for the core's 1 KB instruction memory. It shares the one memory port between the pipeline fetch stage and the program loader, which writes and reads back program words. It issues at most one access per cycle, returns read data one cycle after grant, and flags misaligned or out-of-range addresses. Loader accesses have priority, with a bounded-starvation guarantee for fetch. It sits between the IF stage and the synchronous instruction memory array.

## Interface
- DEPTH, 256: memory depth in 32-bit words; byte range 0 .. DEPTH*4-1
- MAX_LD_BURST, 4: maximum consecutive loader grants while fetch is waiting
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- if_req  input  1  fetch request; held with if_addr until if_gnt
- if_addr  input  32  fetch byte address
- if_flush  input  1  pipeline redirect; kills the fetch response returning this cycle
- if_gnt  output  1  fetch granted this cycle (combinational)
- if_valid  output  1  if_instr valid this cycle
- if_instr  output  32  fetched word
- if_fault  output  1  with if_valid: address misaligned or out of range
- ld_req  input  1  loader request; held with its fields until ld_gnt
- ld_we  input  1  1 = write, 0 = read
- ld_addr  input  32  loader byte address
- ld_wdata  input  32  write data
- ld_gnt  output  1  loader granted this cycle (combinational)
- ld_rvalid  output  1  loader read or fault response valid
- ld_rdata  output  32  loader read data
- ld_fault  output  1  with ld_rvalid: bad address
- mem_en  output  1  memory access strobe
- mem_we  output  1  write enable
- mem_addr  output  $clog2(DEPTH)  word index (byte address [log2(DEPTH)+1:2])
- mem_wdata  output  32  write data
- mem_rdata  input  32  memory read data, valid the cycle after mem_en with mem_we=0

## Operation
- Grant selection, one grant per cycle:
  - Only one request: that requester is granted.
  - Both request: loader wins, unless streak == MAX_LD_BURST; then fetch wins.
- streak counter, width $clog2(MAX_LD_BURST+1):
  - Increments on a loader grant while if_req=1.
  - Clears on a fetch grant, or in any cycle with if_req=0.
  - Saturates at MAX_LD_BURST.
- Address check on the granted address: bad if addr[1:0] != 0 or addr >= DEPTH*4.
  - Bad address: the grant still occurs, mem_en=0, and a response is generated with the fault flag set and data 0.
- Good grant drives mem_en=1, mem_addr, mem_we and mem_wdata from the winner; mem_we=1 only for loader writes.
- Response pipeline: a register holds {valid, source, fault}.
  - Source FETCH: response on if_valid/if_instr/if_fault.
  - Source LOAD and read (or fault): response on ld_rvalid/ld_rdata/ld_fault.
  - Successful loader writes produce no response.
- Flush: if_flush=1 forces if_valid=0 in that cycle and discards that fetch response.
  - A fetch grant in the same cycle as if_flush is still honoured; its response returns next cycle.
- Data outputs (if_instr, ld_rdata) pass mem_rdata through only when the matching valid is high, else 0.

## Timing
- Grant in cycle N: memory access in cycle N; response valid in cycle N+1 (latency 1). Back-to-back grants give one response per cycle.
- Loader write to word W granted in cycle N: a fetch of W granted in N+1 or later returns the new data.
- Reset, synchronous: every output 0, streak=0, response register cleared.
  - A response pending when reset is asserted is dropped.
  - No grants while reset=1.
- Requests asserted in the first cycle after reset deassertion are arbitrated normally.

## Structure
- Package imem_pkg holds:
  - IMEM_DEPTH, IMEM_AW localparams.
  - Source enum {SRC_FETCH, SRC_LOAD}.
  - Response struct {valid, src, fault}.
- Sub-module imem_grant_sel: streak counter plus winner selection. Outputs if_gnt, ld_gnt and the selected source. Instantiated once.
- The top level holds the address check, memory mux and response register.

## Test plan
- Fetch only: if_req at 0x0, 0x4, 0x8 in consecutive cycles -> if_gnt each cycle; if_valid in cycles 2..4 with preloaded words 0x01000093, 0x02A00113, 0x00208023.
- Loader write then fetch: ld write 0x0C800493 to 0x30 in cycle N, fetch 0x30 in N+1 -> if_instr=0x0C800493 in N+2.
- Contention, MAX_LD_BURST=4: both requesters held continuously -> grant sequence L,L,L,L,F,L,L,L,L,F; no fetch waits more than 4 cycles.
- Faults: fetch 0x402 -> if_valid=1, if_fault=1, if_instr=0, mem_en=0; loader read 0x400 -> ld_rvalid=1, ld_fault=1.
- Flush: fetch granted in N, if_flush=1 in N+1 -> if_valid=0 in N+1; fetch granted in N+1 returns normally in N+2.
- Reset mid-operation: fetch granted in N, reset=1 in N+1 -> no if_valid in N+1; all outputs 0 and streak=0 after release.

Source files
------------

// File: rtl/imem_port_ctrl_pkg.sv
// Shared constants, types and the address-check helper for the
// instruction-memory port controller.
package imem_pkg;

  localparam int IMEM_DEPTH        = 256;
  localparam int IMEM_AW           = $clog2(IMEM_DEPTH);
  localparam int IMEM_MAX_LD_BURST = 4;

  typedef enum logic {
    SRC_FETCH = 1'b0,
    SRC_LOAD  = 1'b1
  } src_e;

  typedef struct packed {
    logic valid;
    src_e src;
    logic fault;
  } resp_t;

  localparam resp_t RESP_IDLE = '{valid: 1'b0, src: SRC_FETCH, fault: 1'b0};

  // A byte address is unusable when it is not word aligned or lies past the array.
  function automatic logic addr_is_bad(input logic [31:0] addr, input int unsigned depth);
    logic [33:0] limit;
    limit = 34'(depth) << 2;
    return (addr[1:0] != 2'b00) || ({2'b00, addr} >= limit);
  endfunction

endpackage

// File: rtl/imem_port_ctrl_if.sv
// Bundle of the fetch, loader and memory-array signals around the port
// controller; slave is the controller's view, master the surrounding logic.
interface imem_port_ctrl_if #(
  parameter int AW = imem_pkg::IMEM_AW
);

  logic          if_req;
  logic [31:0]   if_addr;
  logic          if_flush;
  logic          if_gnt;
  logic          if_valid;
  logic [31:0]   if_instr;
  logic          if_fault;

  logic          ld_req;
  logic          ld_we;
  logic [31:0]   ld_addr;
  logic [31:0]   ld_wdata;
  logic          ld_gnt;
  logic          ld_rvalid;
  logic [31:0]   ld_rdata;
  logic          ld_fault;

  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata;

  modport slave (
    input  if_req, if_addr, if_flush,
    output if_gnt, if_valid, if_instr, if_fault,
    input  ld_req, ld_we, ld_addr, ld_wdata,
    output ld_gnt, ld_rvalid, ld_rdata, ld_fault,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output if_req, if_addr, if_flush,
    input  if_gnt, if_valid, if_instr, if_fault,
    output ld_req, ld_we, ld_addr, ld_wdata,
    input  ld_gnt, ld_rvalid, ld_rdata, ld_fault,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );

endinterface

// File: rtl/imem_port_ctrl_grant_sel.sv
// Winner selection between fetch and loader, with a streak counter that
// bounds how long a waiting fetch can be starved by loader traffic.
module imem_grant_sel
  import imem_pkg::*;
#(
  parameter int MAX_LD_BURST = IMEM_MAX_LD_BURST
) (
  input  logic clk,
  input  logic reset,
  input  logic if_req,
  input  logic ld_req,
  output logic if_gnt,
  output logic ld_gnt,
  output src_e sel_src
);

  localparam int            SW         = $clog2(MAX_LD_BURST + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_LD_BURST);

  logic [SW-1:0] streak_q;
  logic [SW-1:0] streak_d;
  logic          fetch_wins;

  // Loader has priority until it has won MAX_LD_BURST times in a row over a waiting fetch.
  always_comb begin
    fetch_wins = 1'b0;
    if_gnt     = 1'b0;
    ld_gnt     = 1'b0;
    sel_src    = SRC_FETCH;
    if (reset) begin
      fetch_wins = 1'b0;
      if_gnt     = 1'b0;
      ld_gnt     = 1'b0;
      sel_src    = SRC_FETCH;
    end else begin
      fetch_wins = if_req && (!ld_req || (streak_q == STREAK_MAX));
      if_gnt     = fetch_wins;
      ld_gnt     = ld_req && !fetch_wins;
      sel_src    = ld_gnt ? SRC_LOAD : SRC_FETCH;
    end
  end

  always_comb begin
    streak_d = streak_q;
    if (!if_req || if_gnt) begin
      streak_d = '0;
    end else if (ld_gnt && (streak_q != STREAK_MAX)) begin
      streak_d = streak_q + SW'(1);
    end else begin
      streak_d = streak_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      streak_q <= '0;
    end else begin
      streak_q <= streak_d;
    end
  end

endmodule

// File: rtl/imem_port_ctrl.sv
// Single-port access controller for the instruction memory: arbitrates fetch
// and loader, checks addresses, drives the array and routes one-cycle responses.
module imem_port_ctrl
  import imem_pkg::*;
#(
  parameter int DEPTH        = IMEM_DEPTH,
  parameter int MAX_LD_BURST = IMEM_MAX_LD_BURST
) (
  input  logic             clk,
  input  logic             reset,
  imem_port_ctrl_if.slave  bus
);

  localparam int AW = $clog2(DEPTH);

  logic          if_gnt;
  logic          ld_gnt;
  src_e          sel_src;

  logic          gnt_any;
  logic [31:0]   gnt_addr;
  logic          gnt_we;
  logic          gnt_bad;

  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;

  resp_t         resp_q;
  resp_t         resp_d;
  logic          resp_live;
  logic          if_valid;
  logic          ld_rvalid;

  imem_grant_sel #(
    .MAX_LD_BURST (MAX_LD_BURST)
  ) u_grant_sel (
    .clk     (clk),
    .reset   (reset),
    .if_req  (bus.if_req),
    .ld_req  (bus.ld_req),
    .if_gnt  (if_gnt),
    .ld_gnt  (ld_gnt),
    .sel_src (sel_src)
  );

  always_comb begin
    gnt_any = if_gnt | ld_gnt;
    if (sel_src == SRC_LOAD) begin
      gnt_addr = bus.ld_addr;
      gnt_we   = bus.ld_we;
    end else begin
      gnt_addr = bus.if_addr;
      gnt_we   = 1'b0;
    end
    gnt_bad = addr_is_bad(gnt_addr, DEPTH);
  end

  // A faulting grant is still consumed but never reaches the array.
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = 32'h0000_0000;
    if (gnt_any && !gnt_bad) begin
      mem_en    = 1'b1;
      mem_we    = gnt_we;
      mem_addr  = gnt_addr[AW+1:2];
      mem_wdata = gnt_we ? bus.ld_wdata : 32'h0000_0000;
    end else begin
      mem_en    = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = 32'h0000_0000;
    end
  end

  // Clean loader writes are the only grants that return nothing.
  always_comb begin
    resp_d = RESP_IDLE;
    if (gnt_any && ((sel_src == SRC_FETCH) || gnt_bad || !gnt_we)) begin
      resp_d.valid = 1'b1;
      resp_d.src   = sel_src;
      resp_d.fault = gnt_bad;
    end else begin
      resp_d = RESP_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      resp_q <= RESP_IDLE;
    end else begin
      resp_q <= resp_d;
    end
  end

  // Reset and flush squash the returning response in the same cycle they are seen.
  always_comb begin
    resp_live = resp_q.valid && !reset;
    if_valid  = resp_live && (resp_q.src == SRC_FETCH) && !bus.if_flush;
    ld_rvalid = resp_live && (resp_q.src == SRC_LOAD);
  end

  assign bus.if_gnt    = if_gnt;
  assign bus.ld_gnt    = ld_gnt;
  assign bus.mem_en    = mem_en;
  assign bus.mem_we    = mem_we;
  assign bus.mem_addr  = mem_addr;
  assign bus.mem_wdata = mem_wdata;

  assign bus.if_valid  = if_valid;
  assign bus.if_fault  = if_valid && resp_q.fault;
  assign bus.if_instr  = (if_valid && !resp_q.fault) ? bus.mem_rdata : 32'h0000_0000;

  assign bus.ld_rvalid = ld_rvalid;
  assign bus.ld_fault  = ld_rvalid && resp_q.fault;
  assign bus.ld_rdata  = (ld_rvalid && !resp_q.fault) ? bus.mem_rdata : 32'h0000_0000;

endmodule

// File: tb/tb_imem_port_ctrl.sv
// Directed and randomized bench for imem_port_ctrl against a cycle-level
// reference model built from the arbitration and response rules.
module tb_imem_port_ctrl;
  import imem_pkg::*;

  localparam int MAXB = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  imem_port_ctrl_if b ();

  imem_port_ctrl #(.DEPTH(256), .MAX_LD_BURST(MAXB)) dut (
    .clk   (clk),
    .reset (rst),
    .bus   (b)
  );

  int total = 0;
  int bad   = 0;

  function automatic logic [31:0] init_word(input int w);
    case (w)
      0:       return 32'h0100_0093;
      1:       return 32'h02A0_0113;
      2:       return 32'h0020_8023;
      default: return (32'h9E37_79B9 * 32'(w)) ^ 32'h0BAD_F00D;
    endcase
  endfunction

  // Synchronous memory array attached to the controller.
  logic [31:0] mem_img [256];
  logic [31:0] rdata_q = 32'h0;
  logic        loaded  = 1'b0;
  always @(posedge clk) begin
    if (!loaded) begin
      for (int i = 0; i < 256; i++) mem_img[i] <= init_word(i);
      loaded <= 1'b1;
    end else if (b.mem_en) begin
      if (b.mem_we) mem_img[b.mem_addr] <= b.mem_wdata;
      else          rdata_q <= mem_img[b.mem_addr];
    end
  end
  assign b.mem_rdata = rdata_q;

  // Reference model state.
  logic [31:0] ref_mem [256];
  int          m_streak;
  bit          p_valid, p_fetch, p_fault;
  logic [31:0] p_data;
  bit          exp_if_gnt, exp_ld_gnt;

  logic        o_if_gnt, o_ld_gnt, o_mem_en, o_if_valid, o_if_fault, o_ld_rvalid, o_ld_fault;
  logic [31:0] o_if_instr, o_ld_rdata;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_in(input bit ir, input logic [31:0] ia, input bit lr, input bit lw,
                        input logic [31:0] la, input logic [31:0] lwd, input bit fl);
    b.if_req = ir; b.if_addr = ia; b.ld_req = lr; b.ld_we = lw;
    b.ld_addr = la; b.ld_wdata = lwd; b.if_flush = fl;
  endtask

  task automatic idle();
    set_in(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
  endtask

  // One clock cycle: predict, compare, advance the model, then cross the edge.
  task automatic step();
    logic [31:0] a;
    bit ef, el, bad_a, e_en, e_we, e_ifv, e_iff, e_ldv, e_ldf;
    logic [31:0] e_ifd, e_ldd;
    ef = 0; el = 0; bad_a = 0; a = 32'h0; e_en = 0; e_we = 0;
    e_ifv = 0; e_iff = 0; e_ldv = 0; e_ldf = 0; e_ifd = 32'h0; e_ldd = 32'h0;
    #4;
    o_if_gnt = b.if_gnt; o_ld_gnt = b.ld_gnt; o_mem_en = b.mem_en;
    o_if_valid = b.if_valid; o_if_instr = b.if_instr; o_if_fault = b.if_fault;
    o_ld_rvalid = b.ld_rvalid; o_ld_rdata = b.ld_rdata; o_ld_fault = b.ld_fault;
    if (!rst) begin
      ef    = b.if_req && (!b.ld_req || m_streak == MAXB);
      el    = b.ld_req && !ef;
      a     = ef ? b.if_addr : b.ld_addr;
      bad_a = (a[1:0] != 2'b00) || (a >= 32'd1024);
      e_ifv = p_valid && p_fetch && !b.if_flush;
      e_iff = e_ifv && p_fault;
      e_ifd = (e_ifv && !p_fault) ? p_data : 32'h0;
      e_ldv = p_valid && !p_fetch;
      e_ldf = e_ldv && p_fault;
      e_ldd = (e_ldv && !p_fault) ? p_data : 32'h0;
      e_en  = (ef || el) && !bad_a;
      e_we  = e_en && el && b.ld_we;
    end
    check("if_gnt",    32'(o_if_gnt),    32'(ef));
    check("ld_gnt",    32'(o_ld_gnt),    32'(el));
    check("mem_en",    32'(o_mem_en),    32'(e_en));
    check("mem_we",    32'(b.mem_we),    32'(e_we));
    check("if_valid",  32'(o_if_valid),  32'(e_ifv));
    check("if_fault",  32'(o_if_fault),  32'(e_iff));
    check("if_instr",  o_if_instr,       e_ifd);
    check("ld_rvalid", 32'(o_ld_rvalid), 32'(e_ldv));
    check("ld_fault",  32'(o_ld_fault),  32'(e_ldf));
    check("ld_rdata",  o_ld_rdata,       e_ldd);
    if (e_en) check("mem_addr", 32'(b.mem_addr), 32'(a[9:2]));
    if (e_we) check("mem_wdata", b.mem_wdata, b.ld_wdata);
    exp_if_gnt = ef;
    exp_ld_gnt = el;
    if (rst) begin
      m_streak = 0;
      p_valid  = 0;
    end else begin
      if (!b.if_req || ef)               m_streak = 0;
      else if (el && m_streak < MAXB)    m_streak++;
      p_valid = (ef || el) && (ef || bad_a || !b.ld_we);
      p_fetch = ef;
      p_fault = bad_a;
      p_data  = bad_a ? 32'h0 : ref_mem[a[9:2]];
      if (el && b.ld_we && !bad_a) ref_mem[a[9:2]] = b.ld_wdata;
    end
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rand_addr();
    int r;
    r = $urandom_range(0, 9);
    if (r < 7)       return 32'($urandom_range(0, 31)) << 2;
    else if (r == 7) return (32'($urandom_range(0, 1023))) | 32'd1;
    else if (r == 8) return 32'h400 + (32'($urandom_range(0, 63)) << 2);
    else             return 32'hFFFF_FFFC;
  endfunction

  initial begin
    string seq;
    bit pend_if, pend_ld;
    for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
    m_streak = 0; p_valid = 0; p_fetch = 0; p_fault = 0; p_data = 32'h0;
    rst = 1'b1;
    idle();
    @(posedge clk);
    #1;
    step();
    step();
    rst = 1'b0;

    // Fetch-only stream of three words.
    set_in(1'b1, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0); step();
    check("tp_fetch_gnt0", 32'(o_if_gnt), 32'd1);
    set_in(1'b1, 32'h4, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0); step();
    check("tp_fetch_w0", o_if_instr, 32'h0100_0093);
    set_in(1'b1, 32'h8, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0); step();
    check("tp_fetch_w1", o_if_instr, 32'h02A0_0113);
    idle(); step();
    check("tp_fetch_w2", o_if_instr, 32'h0020_8023);

    // Loader write followed immediately by a fetch of the same word.
    set_in(1'b0, 32'h0, 1'b1, 1'b1, 32'h30, 32'h0C80_0493, 1'b0); step();
    set_in(1'b1, 32'h30, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0); step();
    idle(); step();
    check("tp_wr_then_fetch", o_if_instr, 32'h0C80_0493);

    // Sustained contention.
    seq = "";
    for (int i = 0; i < 10; i++) begin
      set_in(1'b1, 32'h10, 1'b1, 1'b0, 32'h20, 32'h0, 1'b0); step();
      seq = {seq, o_ld_gnt ? "L" : (o_if_gnt ? "F" : "-")};
    end
    total++;
    assert (seq == "LLLLFLLLLF") else begin
      bad++;
      $error("FAIL grant_seq: observed %s expected LLLLFLLLLF", seq);
    end
    idle(); step();

    // Misaligned fetch and out-of-range loader read.
    set_in(1'b1, 32'h402, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0); step();
    check("tp_fault_fetch_memen", 32'(o_mem_en), 32'd0);
    set_in(1'b0, 32'h0, 1'b1, 1'b0, 32'h400, 32'h0, 1'b0); step();
    check("tp_fault_fetch_v", 32'(o_if_valid), 32'd1);
    check("tp_fault_fetch_f", 32'(o_if_fault), 32'd1);
    check("tp_fault_fetch_d", o_if_instr, 32'h0);
    idle(); step();
    check("tp_fault_ld_v", 32'(o_ld_rvalid), 32'd1);
    check("tp_fault_ld_f", 32'(o_ld_fault), 32'd1);

    // Flush kills the returning response, not the fetch granted alongside it.
    set_in(1'b1, 32'h4, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0); step();
    set_in(1'b1, 32'h8, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1); step();
    check("tp_flush_kill", 32'(o_if_valid), 32'd0);
    check("tp_flush_gnt", 32'(o_if_gnt), 32'd1);
    idle(); step();
    check("tp_flush_next", o_if_instr, 32'h0020_8023);

    // Reset mid-operation: streak built up, pending loader response dropped.
    for (int i = 0; i < 3; i++) begin
      set_in(1'b1, 32'h0, 1'b1, 1'b0, 32'h20, 32'h0, 1'b0); step();
    end
    rst = 1'b1; step();
    check("tp_rst_drop_ld", 32'(o_ld_rvalid), 32'd0);
    check("tp_rst_no_gnt", 32'({o_if_gnt, o_ld_gnt}), 32'd0);
    rst = 1'b0;
    check("tp_rst_streak", 32'(dut.u_grant_sel.streak_q), 32'd0);
    set_in(1'b1, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0); step();
    check("tp_rst_first_gnt", 32'(o_if_gnt), 32'd1);
    set_in(1'b1, 32'h4, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    rst = 1'b1; step();
    check("tp_rst_drop_if", 32'(o_if_valid), 32'd0);
    rst = 1'b0;
    idle(); step();
    check("tp_rst_quiet", 32'({o_if_valid, o_ld_rvalid, o_mem_en}), 32'd0);
    check("tp_rst_streak2", 32'(dut.u_grant_sel.streak_q), 32'd0);

    // Randomized traffic with held requests.
    pend_if = 0; pend_ld = 0;
    for (int i = 0; i < 600; i++) begin
      if (!pend_if && $urandom_range(0, 3) != 0) begin
        pend_if = 1; b.if_addr = rand_addr();
      end
      if (!pend_ld && $urandom_range(0, 1) != 0) begin
        pend_ld = 1; b.ld_addr = rand_addr(); b.ld_we = 1'($urandom_range(0, 1));
        b.ld_wdata = $urandom;
      end
      b.if_req = pend_if;
      b.ld_req = pend_ld;
      b.if_flush = ($urandom_range(0, 7) == 0);
      step();
      if (exp_if_gnt) pend_if = 0;
      if (exp_ld_gnt) pend_ld = 0;
    end
    idle(); step();
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
